// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit byte buffer.
package uart_pkg;

    localparam int DW          = 8;     // data width in bits
    localparam int AW          = 4;     // address width, depth = 2**AW
    localparam int ACK_TIMEOUT = 1023;  // cycles to wait for txd_flag to fall

    // Transmit-side sequencer states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array for the byte FIFO: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
    parameter int DW = uart_pkg::DW,
    parameter int AW = uart_pkg::AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Store one byte per accepted write; contents need no reset because
    // occupancy is tracked by the pointers and count in the parent.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO between the UART receive path and the transmitter,
// draining one byte at a time through the txd_cmd / txd_flag handshake.
//
// Handshake with the transmitter: txd_cmd is a one-cycle request carrying
// txd_data. The transmitter acknowledges by pulling txd_flag low (busy) and
// signals completion by returning it high (idle). If txd_flag never falls
// within ACK_TIMEOUT cycles the same byte is requested again. A new byte is
// only loaded while txd_flag is high.
module uart_tx_fifo #(
    parameter int DW          = uart_pkg::DW,
    parameter int AW          = uart_pkg::AW,
    parameter int ACK_TIMEOUT = uart_pkg::ACK_TIMEOUT
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DW-1:0]       wr_data,
    output logic                full,
    output logic                empty,
    output logic [AW:0]         count,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic [DW-1:0]       txd_data,
    output logic                txd_cmd,
    input  logic                txd_flag,
    output uart_pkg::tx_state_e state_o
);
    import uart_pkg::*;

    localparam int          TW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    tx_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] txd_data_q, txd_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] rd_data;
    logic          pop;
    logic          wr_accept;

    uart_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk_i   (clk50M),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Sequencer: wait for data and an idle transmitter, pop one byte,
    // pulse txd_cmd, then follow txd_flag low and back high.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        txd_data_d = txd_data_q;
        tmo_d      = tmo_q;
        pop        = 1'b0;
        txd_cmd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && txd_flag) state_d = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                txd_data_d = rd_data;
                rd_ptr_d   = rd_ptr_q + AW'(1);
                state_d    = START;
            end
            START: begin
                txd_cmd = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!txd_flag) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
                    state_d = START;  // no acknowledge: reissue the held byte
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (txd_flag) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop in the same cycle frees a slot, so a write
    // to a full FIFO is accepted then and only dropped otherwise.
    always_comb begin
        wr_accept = wr_en && (!full_q || pop);
        wr_ptr_d  = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d   = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_accept && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        ovf_d = ovf_q;
        if (wr_en && !wr_accept) begin
            ovf_d = 1'b1;             // set wins over a same-cycle clear
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State, pointers and flags; empty/full are registered from count_d
    // so all three always agree in the same cycle.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            txd_data_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH);
            ovf_q      <= ovf_d;
            txd_data_q <= txd_data_d;
            tmo_q      <= tmo_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign txd_data = txd_data_q;
    assign state_o  = state_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the UART receive path and the uart transmitter stage.
- Accepts received bytes as single-cycle strobes and stores them in a circular FIFO.
- Drains bytes one at a time to the transmitter using its txd_cmd / txd_data / txd_flag handshake, so back-to-back received bytes are not lost while the transmitter is busy.

Parameters:
- DW, 8, data width in bits.
- AW, 4, address width; FIFO depth = 2**AW (16 entries).
- ACK_TIMEOUT, 1023, clk50M cycles to wait for txd_flag to fall after txd_cmd before the command is reissued.

Ports:
- clk50M  in  1  system clock, single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  one-cycle write strobe (one byte per pulse).
- wr_data  in  DW  byte to store; sampled when wr_en=1.
- full  out  1  FIFO holds 2**AW entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  AW+1  current occupancy, 0..2**AW.
- overflow  out  1  sticky flag: a write was dropped.
- clr_ovf  in  1  synchronous clear of overflow.
- txd_data  out  DW  byte presented to the transmitter.
- txd_cmd  out  1  one-cycle transmit request pulse.
- txd_flag  in  1  transmitter status: 0 = busy, 1 = idle/done.

Behaviour:
- Reset (async, rst=1): rd/wr pointers 0, count 0, empty=1, full=0, overflow=0, txd_cmd=0, txd_data=0, FSM=IDLE, timeout counter 0.
- Write:
  - wr_en=1 and not full: store at wr_ptr; wr_ptr+1 wraps modulo 2**AW; count+1.
  - wr_en=1 and full: byte dropped and overflow set to 1. Exception: if a pop occurs in the same cycle, the write is accepted and count is unchanged.
- Pop occurs only in the LOAD state.
- Simultaneous write and pop: count unchanged; both pointers advance.
- Pop from empty cannot occur (LOAD is entered only when empty=0).
- overflow: set has priority over clr_ovf in the same cycle.
- full, empty and count are registered and consistent in the same cycle; a written byte is visible in empty/count one cycle after wr_en.
- FSM:
  - IDLE: if empty=0 and txd_flag=1 -> LOAD.
  - LOAD: txd_data <= mem[rd_ptr]; rd_ptr+1 (wraps); count-1 -> START.
  - START: txd_cmd=1 for exactly this cycle; timeout counter cleared -> WAIT_BUSY.
  - WAIT_BUSY: if txd_flag=0 -> WAIT_DONE; else if counter = ACK_TIMEOUT -> START (reissue the same byte); else counter+1.
  - WAIT_DONE: if txd_flag=1 -> IDLE.
- txd_data is held stable from LOAD exit until the FSM returns to IDLE.
- Latency: a write into an empty FIFO with the transmitter idle gives txd_cmd=1 three cycles after the wr_en cycle (write, IDLE->LOAD, LOAD->START).
- Reset mid-transfer: FSM returns to IDLE and FIFO contents are discarded. txd_cmd=0 immediately; the transmitter finishes its current byte independently.
- Count arithmetic is AW+1 bits wide, so count=16 is representable with no wrap.

Decomposition:
- Shared package uart_pkg: DW, default AW, ACK_TIMEOUT, FSM state encoding (IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE).
- One sub-module: uart_fifo_mem, a dual-pointer register array with a synchronous write port and an asynchronous read port, 2**AW x DW.
- The FSM, pointers and flags stay in uart_tx_fifo.

Test Plan:
- Reset release, write 0xA5 with txd_flag=1 -> txd_cmd pulse 3 cycles later with txd_data=0xA5; model drops txd_flag for 10 cycles then raises it -> FSM back in IDLE, empty=1.
- Write 0x01..0x05 back-to-back while the model is busy (txd_flag=0) -> count=5. On release, bytes appear in order 01..05, one txd_cmd each; each waits for txd_flag to go 0 then 1.
- Write 17 bytes with the transmitter stalled -> full=1, count=16, overflow=1, 17th byte absent from the output. clr_ovf -> overflow=0.
- Full FIFO, wr_en in the same cycle as a LOAD pop -> byte accepted, count stays 16, overflow stays 0.
- Model never drops txd_flag -> txd_cmd reissued every ACK_TIMEOUT+2 cycles with the same txd_data; when the model finally responds, the byte is sent once and the next byte follows.
- Assert rst during WAIT_DONE with 3 bytes queued -> count=0, empty=1, txd_cmd=0 immediately; no further txd_cmd after release without new writes.
- Wrap check: push and pop 40 bytes in a streaming pattern -> all 40 delivered in order across the pointer wrap.
